// File: rtl/divseq_pkg.sv
// Shared types and sizing for the divseq sequential divider.
package divseq_pkg;

  localparam int DIVSEQ_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } divseq_state_t;

  // Iteration counter width; never let it collapse to zero bits.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/divseq_if.sv
// Start/done request and result bundle between a requester and divseq.
interface divseq_if #(
  parameter int WIDTH = 4
);
  logic             START;
  logic [WIDTH-1:0] DIVIDEND;
  logic [WIDTH-1:0] DIVISOR;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] QUOTIENT;
  logic [WIDTH-1:0] REMAINDER;
  logic             DIV0;

  modport master (
    output START, DIVIDEND, DIVISOR,
    input  BUSY, DONE, QUOTIENT, REMAINDER, DIV0
  );

  modport slave (
    input  START, DIVIDEND, DIVISOR,
    output BUSY, DONE, QUOTIENT, REMAINDER, DIV0
  );
endinterface

// File: rtl/addsub.sv
// Combinational WIDTH-bit adder/subtractor; SUB=1 computes A-B with COUT=1 meaning no borrow.
module addsub #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  output logic [WIDTH-1:0] S,
  output logic             COUT
);
  logic [WIDTH-1:0] w_b;

  assign w_b       = B ^ {WIDTH{SUB}};
  assign {COUT, S} = {1'b0, A} + {1'b0, w_b} + (WIDTH+1)'(SUB);
endmodule

// File: rtl/divseq.sv
// Sequential restoring divider: one trial subtraction per clock through a shared addsub.
module divseq
  import divseq_pkg::*;
#(
  parameter int WIDTH = DIVSEQ_WIDTH
) (
  input  logic    CLK,
  input  logic    RST,
  divseq_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);

  divseq_state_t    r_state, w_next;
  logic [WIDTH-1:0] r_q, r_r, r_d;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quo, r_rem;
  logic             r_div0, r_done;

  logic [WIDTH-1:0] w_t, w_s, w_r_nxt, w_q_nxt;
  logic             w_cout, w_last;

  // Shift the next dividend bit into the partial remainder; it always fits in WIDTH bits.
  assign w_t     = {r_r[WIDTH-2:0], r_q[WIDTH-1]};
  assign w_r_nxt = w_cout ? w_s : w_t;
  assign w_q_nxt = {r_q[WIDTH-2:0], w_cout};
  assign w_last  = (r_cnt == CW'(WIDTH-1));

  addsub #(.WIDTH(WIDTH)) u_addsub (
    .A    (w_t),
    .B    (r_d),
    .SUB  (1'b1),
    .S    (w_s),
    .COUT (w_cout)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.START) w_next = (bus.DIVISOR == '0) ? FIN : RUN;
      RUN:     if (w_last) w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_r     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_div0  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: if (bus.START) begin
          r_d   <= bus.DIVISOR;
          r_q   <= bus.DIVIDEND;
          r_r   <= '0;
          r_cnt <= '0;
          // Divide by zero skips RUN and publishes its fixed result on the accept edge.
          if (bus.DIVISOR == '0) begin
            r_quo  <= '1;
            r_rem  <= bus.DIVIDEND;
            r_div0 <= 1'b1;
            r_done <= 1'b1;
          end
        end
        RUN: begin
          r_r   <= w_r_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_quo  <= w_q_nxt;
            r_rem  <= w_r_nxt;
            r_div0 <= 1'b0;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.BUSY      = (r_state != IDLE);
  assign bus.DONE      = r_done;
  assign bus.QUOTIENT  = r_quo;
  assign bus.REMAINDER = r_rem;
  assign bus.DIV0      = r_div0;
endmodule

// File: doc/divseq.md
# divseq

Sequential unsigned restoring divider that sequences one shared `addsub` instance in SUB mode, one trial subtraction per clock. It turns the combinational add/subtract datapath into a multi-cycle arithmetic unit with a start/done handshake. It sits beside `addsub` in the arithmetic components and is the first clocked user of that block.

## Interface
- `WIDTH`, default 4: operand width, which is also the width of the `addsub` instance.
- `CLK` in, 1 bit: single clock; all state updates on the rising edge.
- `RST` in, 1 bit: asynchronous, active-high reset.
- `START` in, 1 bit: request a division. Sampled only in IDLE.
- `DIVIDEND` in, WIDTH bits: unsigned dividend, captured on accept.
- `DIVISOR` in, WIDTH bits: unsigned divisor, captured on accept.
- `BUSY` out, 1 bit: high in every state except IDLE.
- `DONE` out, 1 bit: one-cycle pulse marking a result.
- `QUOTIENT` out, WIDTH bits: registered result.
- `REMAINDER` out, WIDTH bits: registered result.
- `DIV0` out, 1 bit: the last completed operation had DIVISOR == 0.

## Operation
- States are IDLE, RUN and FIN.
- **IDLE:**
  - If `START` is high on an edge, latch D = DIVISOR, set Q = DIVIDEND, R = 0 and CNT = 0.
  - Go to RUN, or go straight to FIN if DIVISOR == 0.
- **RUN, one iteration per edge:**
  - T = {R[WIDTH-2:0], Q[WIDTH-1]}.
  - `addsub` gets A = T, B = D, SUB = 1.
  - If COUT = 1 (no borrow, T ≥ D): R ← S and Q ← {Q[WIDTH-2:0], 1}.
  - Otherwise: R ← T and Q ← {Q[WIDTH-2:0], 0}.
  - CNT increments each edge. On the edge where CNT == WIDTH-1, go to FIN.
- **FIN:**
  - `QUOTIENT` = Q, `REMAINDER` = R, `DIV0` = 0, `DONE` = 1.
  - The next edge returns to IDLE.
- **Divide-by-zero path:** FIN loads `QUOTIENT` = all ones, `REMAINDER` = DIVIDEND and `DIV0` = 1.
- **Width rule:** the partial remainder never exceeds WIDTH bits, because T ≤ the dividend prefix < 2^WIDTH. No extra carry bit is kept. `COUT` of `addsub` is the only compare signal.
- **Output hold:** `QUOTIENT`, `REMAINDER` and `DIV0` are updated only in FIN. They hold until the next completion.
- **START outside IDLE:** ignored in RUN and FIN, with no queuing. The requester must re-assert `START` after `BUSY` falls.
- **Operand stability:** `DIVIDEND`/`DIVISOR` changes after accept have no effect.

## Timing
- **Reset values:** state IDLE, `BUSY` 0, `DONE` 0, `QUOTIENT` 0, `REMAINDER` 0, `DIV0` 0, CNT 0.
- **Reset mid-operation:** `RST` aborts immediately (asynchronous). No `DONE` is issued and all outputs return to their reset values.
- **Normal latency** (accept edge = edge k):
  - `BUSY` is high from k.
  - RUN covers edges k+1 … k+WIDTH.
  - `DONE` is high for the cycle after edge k+WIDTH.
  - IDLE resumes at edge k+WIDTH+1.
  - WIDTH = 4 gives a 6-cycle start-to-start period.
- **Divide-by-zero latency:** FIN is entered at edge k, `DONE` is high after edge k, and IDLE resumes at edge k+1.
- **Outputs:** `DONE`, `QUOTIENT`, `REMAINDER` and `DIV0` are registered, with no combinational path from inputs. `BUSY` is decoded from state only.
- **Back-to-back:** `START` held high continuously is accepted on the first IDLE edge after each `DONE`.

## Structure
- **Package `divseq_pkg`:**
  - State enum `divseq_state_t` {IDLE, RUN, FIN}.
  - Default `WIDTH` constant.
  - Counter width: `$clog2(WIDTH)`.
- **Sub-module:** one `addsub` instance, with SUB tied to 1. This block adds no arithmetic of its own beyond the shifts and the counter.
- **Registers:** a single clocked process for state, R, Q, D, CNT and the outputs. Next-state decode is combinational.

## Test plan
- **10 / 3:** `START` one cycle → `BUSY` for 5 cycles, `DONE` after 5 edges, `QUOTIENT` = 3, `REMAINDER` = 1, `DIV0` = 0.
- **9 / 1 then 15 / 15, back-to-back with `START` held high:**
  - 9 / 1 gives `QUOTIENT` 9, `REMAINDER` 0.
  - 15 / 15 gives `QUOTIENT` 1, `REMAINDER` 0.
  - The second accept happens exactly one edge after the first `DONE`.
- **7 / 0:** `DONE` one edge after accept, `QUOTIENT` = 15, `REMAINDER` = 7, `DIV0` = 1. A following 0 / 5 gives 0 R 0 with `DIV0` cleared.
- **Busy handling:** start 15 / 2 and, during RUN, pulse `START` with 6 / 3 on the inputs. Required: the result is 7 R 1 and exactly one `DONE`.
- **Reset mid-operation:** assert `RST` between clock edges in RUN. Required: `BUSY`, `DONE` and the outputs go to 0 immediately, and a subsequent 12 / 5 gives 2 R 2.
- **Self-check:** exhaustive sweep of all 256 operand pairs for WIDTH = 4, compared against a `/` and `%` reference model.
